// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_pkg : shared state encoding and watchdog sizing
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BUSY0 = 2'b01,
    ST_BUSY1 = 2'b10
  } state_t;

  localparam int C_DEFAULT_TIMEOUT = 255;
  localparam int C_WDOG_W          = 8;

  // Counter only has to reach TIMEOUT-1 before the abort fires.
  function automatic int wdog_width(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux_2x1_32b.sv
// ---------------------------------------------------------------------------
// mux_2x1_32b : two-input word multiplexer (sel=0 picks d0)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mux_2x1_32b #(
  parameter int WIDTH = 32
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  output logic [WIDTH-1:0] y
);

  assign y = sel ? d1 : d0;

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter : fair two-requester arbiter for the shared memory port,
//                    with completion pulses and a per-access watchdog
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = C_DEFAULT_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] addr0,
  input  logic [WIDTH-1:0] addr1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  input  logic             we0,
  input  logic             we1,
  input  logic             mem_ready,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             mem_valid,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_we,
  output logic             sel,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             err,
  output logic [WIDTH-1:0] rdata
);

  localparam int CNT_W = (wdog_width(TIMEOUT) > C_WDOG_W) ? wdog_width(TIMEOUT) : C_WDOG_W;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_next;
  logic             r_last;
  logic             r_sel;
  logic             r_done0;
  logic             r_done1;
  logic             r_err;
  logic [WIDTH-1:0] r_rdata;
  logic [CNT_W-1:0] r_cnt;
  logic             w_busy;
  logic             w_expire;
  logic             w_finish;

  assign w_busy   = (r_state == ST_BUSY0) || (r_state == ST_BUSY1);
  // A late MemReady on the final watchdog cycle still counts as success.
  assign w_expire = w_busy && !mem_ready && (r_cnt == C_CNT_LAST);
  assign w_finish = w_busy && (mem_ready || w_expire);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req0 && req1)
          w_next = r_last ? ST_BUSY0 : ST_BUSY1;
        else if (req0)
          w_next = ST_BUSY0;
        else if (req1)
          w_next = ST_BUSY1;
      end
      // The finishing requester is never re-granted on its own completion edge.
      ST_BUSY0: if (w_finish) w_next = req1 ? ST_BUSY1 : ST_IDLE;
      ST_BUSY1: if (w_finish) w_next = req0 ? ST_BUSY0 : ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last  <= 1'b1;
      r_sel   <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
      r_cnt   <= '0;
    end else begin
      r_sel   <= (w_next == ST_BUSY1);
      r_done0 <= w_finish && (r_state == ST_BUSY0);
      r_done1 <= w_finish && (r_state == ST_BUSY1);
      r_err   <= w_expire;
      if (w_busy && mem_ready)
        r_rdata <= mem_rdata;
      if (w_finish)
        r_last <= (r_state == ST_BUSY1);
      if (w_busy && !w_finish)
        r_cnt <= r_cnt + CNT_W'(1);
      else
        r_cnt <= '0;
    end
  end

  mux_2x1_32b #(.WIDTH(WIDTH)) u_addr_mux (
    .sel (r_sel),
    .d0  (addr0),
    .d1  (addr1),
    .y   (mem_addr)
  );

  mux_2x1_32b #(.WIDTH(WIDTH)) u_wdata_mux (
    .sel (r_sel),
    .d0  (wdata0),
    .d1  (wdata1),
    .y   (mem_wdata)
  );

  assign mem_we    = r_sel ? we1 : we0;
  assign mem_valid = w_busy;
  assign sel       = r_sel;
  assign gnt0      = (r_state == ST_BUSY0);
  assign gnt1      = (r_state == ST_BUSY1);
  assign done0     = r_done0;
  assign done1     = r_done1;
  assign err       = r_err;
  assign rdata     = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter : directed + random bench against a transaction model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_port_arbiter;

  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 255;

  logic        clk;
  logic        rst_n;
  logic        req0, req1, we0, we1, mem_ready;
  logic [31:0] addr0, addr1, wdata0, wdata1, mem_rdata;
  logic        mem_valid, mem_we, sel, gnt0, gnt1, done0, done1, err;
  logic [31:0] mem_addr, mem_wdata, rdata;

  int n_vec  = 0;
  int n_fail = 0;

  // transaction-level model: who owns the port, how long it has waited
  int          m_owner;
  int          m_wait;
  bit          m_last;
  bit          m_done0, m_done1, m_err;
  logic [31:0] m_rdata;

  mem_port_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .req1      (req1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .we0       (we0),
    .we1       (we1),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .sel       (sel),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .done0     (done0),
    .done1     (done1),
    .err       (err),
    .rdata     (rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_wait  = 0;
    m_last  = 1'b1;
    m_done0 = 1'b0;
    m_done1 = 1'b0;
    m_err   = 1'b0;
    m_rdata = '0;
  endtask

  // Advance the model by one clock edge using the inputs held during the cycle.
  task automatic model_step();
    int  other;
    bit  other_req;
    m_done0 = 1'b0;
    m_done1 = 1'b0;
    m_err   = 1'b0;
    if (m_owner >= 0) begin
      other     = 1 - m_owner;
      other_req = (other == 0) ? req0 : req1;
      if (mem_ready || (m_wait + 1 == TIMEOUT)) begin
        if (m_owner == 0) m_done0 = 1'b1;
        else              m_done1 = 1'b1;
        m_err = !mem_ready;
        if (mem_ready) m_rdata = mem_rdata;
        m_last  = (m_owner == 1);
        m_wait  = 0;
        m_owner = other_req ? other : -1;
      end else begin
        m_wait++;
      end
    end else begin
      if (req0 && req1)  m_owner = m_last ? 0 : 1;
      else if (req0)     m_owner = 0;
      else if (req1)     m_owner = 1;
      m_wait = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check_all();
    @(negedge clk);
    chk("gnt0",      32'(gnt0),      32'(m_owner == 0));
    chk("gnt1",      32'(gnt1),      32'(m_owner == 1));
    chk("mem_valid", 32'(mem_valid), 32'(m_owner >= 0));
    if (m_owner >= 0) begin
      chk("sel",       32'(sel),    32'(m_owner == 1));
      chk("mem_addr",  mem_addr,    (m_owner == 1) ? addr1 : addr0);
      chk("mem_wdata", mem_wdata,   (m_owner == 1) ? wdata1 : wdata0);
      chk("mem_we",    32'(mem_we), 32'((m_owner == 1) ? we1 : we0));
    end
    chk("done0", 32'(done0), 32'(m_done0));
    chk("done1", 32'(done1), 32'(m_done1));
    chk("err",   32'(err),   32'(m_err));
    chk("rdata", rdata,      m_rdata);
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_mem_valid"}, 32'(mem_valid), 32'd0);
    chk({pfx, "_gnt0"},      32'(gnt0),      32'd0);
    chk({pfx, "_gnt1"},      32'(gnt1),      32'd0);
    chk({pfx, "_sel"},       32'(sel),       32'd0);
    chk({pfx, "_done0"},     32'(done0),     32'd0);
    chk({pfx, "_done1"},     32'(done1),     32'd0);
    chk({pfx, "_err"},       32'(err),       32'd0);
    chk({pfx, "_rdata"},     rdata,          32'd0);
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      req0 = 1'b0; req1 = 1'b0; mem_ready = 1'b0;
      check_all();
    end
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      req0 = 1'b0; req1 = 1'b0; mem_ready = 1'b1; mem_rdata = $urandom;
      check_all();
    end
  endtask

  task automatic drive_rand();
    req0 = ($urandom_range(0, 9) < 6);
    req1 = ($urandom_range(0, 9) < 6);
    if (m_owner != 0) begin
      addr0 = $urandom; wdata0 = $urandom; we0 = $urandom_range(0, 1);
    end
    if (m_owner != 1) begin
      addr1 = $urandom; wdata1 = $urandom; we1 = $urandom_range(0, 1);
    end
    mem_ready = ($urandom_range(0, 9) < 4);
    mem_rdata = $urandom;
  endtask

  // Requester 0 with MemReady withheld; race=1 supplies MemReady on the last cycle.
  task automatic run_timeout(input bit race);
    req0 = 1'b1; req1 = 1'b0; mem_ready = 1'b0;
    addr0 = $urandom; wdata0 = $urandom; we0 = $urandom_range(0, 1);
    tick();
    for (int i = 1; i <= TIMEOUT; i++) begin
      req0      = 1'b0;
      req1      = !race && (i >= 100);
      mem_ready = race && (i == TIMEOUT);
      mem_rdata = 32'hA5A5_0000 + 32'(i);
      check_all();
      if (i == TIMEOUT) chk("tmo_last_gnt0", 32'(gnt0), 32'd1);
      tick();
    end
    req1 = 1'b0; mem_ready = 1'b1; mem_rdata = $urandom;
    check_all();
    chk("tmo_done0", 32'(done0), 32'd1);
    chk("tmo_err",   32'(err),   race ? 32'd0 : 32'd1);
    chk("tmo_gnt1",  32'(gnt1),  race ? 32'd0 : 32'd1);
    if (race) chk("tmo_rdata", rdata, 32'hA5A5_0000 + 32'(TIMEOUT));
    drain(2);
  endtask

  initial begin
    rst_n = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0; mem_ready = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; mem_rdata = '0;
    model_reset();
    #1 rst_n = 1'b0;
    #2;
    chk_reset_outputs("por");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(2);

    // single read, completes on the second BUSY cycle
    req0 = 1'b1; addr0 = 32'h0000_0030; we0 = 1'b0; wdata0 = $urandom;
    tick();
    mem_ready = 1'b0;
    check_all();
    chk("rd_addr", mem_addr, 32'h0000_0030);
    tick();
    req0 = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h0010_0000;
    check_all();
    tick();
    mem_ready = 1'b0; mem_rdata = $urandom;
    check_all();
    chk("rd_done0", 32'(done0), 32'd1);
    chk("rd_rdata", rdata,      32'h0010_0000);
    chk("rd_err",   32'(err),   32'd0);
    idle_cycles(1);

    // write through requester 1
    req1 = 1'b1; we1 = 1'b1; wdata1 = 32'h0000_0001; addr1 = $urandom;
    tick();
    req1 = 1'b0; mem_ready = 1'b1;
    check_all();
    chk("wr_we",    32'(mem_we), 32'd1);
    chk("wr_wdata", mem_wdata,   32'h0000_0001);
    chk("wr_sel",   32'(sel),    32'd1);
    tick();
    req0 = 1'b0; req1 = 1'b0; mem_ready = 1'b0;
    check_all();
    chk("wr_done1", 32'(done1), 32'd1);
    idle_cycles(1);

    run_timeout(1'b0);
    idle_cycles(1);
    run_timeout(1'b1);
    idle_cycles(1);

    // reset in the middle of a BUSY1 access
    req1 = 1'b1; addr1 = $urandom; wdata1 = $urandom;
    tick();
    req1 = 1'b0; mem_ready = 1'b0;
    check_all();
    chk("pre_rst_gnt1", 32'(gnt1), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid");
    model_reset();
    req0 = 1'b1; req1 = 1'b1; mem_ready = 1'b1;
    addr0 = $urandom; addr1 = $urandom; wdata0 = $urandom; wdata1 = $urandom;
    @(negedge clk);
    rst_n = 1'b1;

    // contention after reset: first tie goes to requester 0, then strict alternation
    for (int j = 0; j < 8; j++) begin
      tick();
      mem_rdata = $urandom;
      check_all();
      chk("alt_sel",   32'(sel),       32'(j % 2));
      chk("alt_valid", 32'(mem_valid), 32'd1);
    end
    drain(3);

    for (int n = 0; n < 4000; n++) begin
      tick();
      drive_rand();
      check_all();
    end
    drain(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
